cpu_ctrl_fsm: RTL and testbench



---
 rtl/cpu_pkg.sv | 98 +++++++++
 rtl/mem_wait_timer.sv | 47 ++++
 rtl/cpu_ctrl_fsm.sv | 188 ++++++++++++++++++
 tb/tb_cpu_ctrl_fsm.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the multi-cycle CPU control unit:
//   - opcode values the decoder distinguishes (ALU group is 0..OP_EQ)
//   - 4-bit state encoding of the control FSM
//   - fault_code values
//   - ctrl_t bundle of Moore outputs and the per-state decode function
// No ports (package).
// -----------------------------------------------------------------------------
package cpu_pkg;

   // All ALU opcodes (ADD .. EQ) lie in 0..OP_EQ.
   localparam int OP_EQ   = 16;
   localparam int OP_BR   = 17;
   localparam int OP_STW  = 18;
   localparam int OP_LDW  = 19;
   localparam int OP_HALT = 20;

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_FETCH    = 4'd1,
      S_LOAD_IR  = 4'd2,
      S_DECODE   = 4'd3,
      S_AR_ALU   = 4'd4,
      S_AR_ROUT  = 4'd5,
      S_LDW_REQ  = 4'd6,
      S_LDW_MDR  = 4'd7,
      S_LDW_ROUT = 4'd8,
      S_STW_REQ  = 4'd9,
      S_BR       = 4'd10,
      S_HALT     = 4'd11,
      S_FAULT    = 4'd12
   } state_t;

   typedef enum logic [1:0] {
      FC_NONE    = 2'd0,
      FC_ILLEGAL = 2'd1,
      FC_TIMEOUT = 2'd2
   } fault_code_t;

   typedef struct packed {
      logic mem_read;
      logic mem_write;
      logic ir_en;
      logic pc_en;
      logic mdr_en;
      logic br_en;
      logic rf_write;
      logic ldw_en;
      logic data_w_mdr;
      logic instr_done;
      logic halted;
      logic fault;
   } ctrl_t;

   // Moore outputs of each state; everything not listed is 0.
   function automatic ctrl_t state_ctrl(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH:    c.mem_read = 1'b1;
         S_LOAD_IR:  c.ir_en = 1'b1;
         S_AR_ROUT: begin
            c.rf_write   = 1'b1;
            c.instr_done = 1'b1;
         end
         S_LDW_REQ: begin
            c.ldw_en   = 1'b1;
            c.mem_read = 1'b1;
         end
         S_LDW_MDR:  c.mdr_en = 1'b1;
         S_LDW_ROUT: begin
            c.rf_write   = 1'b1;
            c.data_w_mdr = 1'b1;
            c.instr_done = 1'b1;
         end
         S_STW_REQ: begin
            c.ldw_en    = 1'b1;
            c.mem_write = 1'b1;
         end
         S_BR: begin
            c.br_en      = 1'b1;
            c.pc_en      = 1'b1;
            c.instr_done = 1'b1;
         end
         S_HALT:     c.halted = 1'b1;
         S_FAULT:    c.fault = 1'b1;
         default:    c = '0;
      endcase
      return c;
   endfunction

   // States that hold a memory strobe and wait for mem_ack.
   function automatic logic is_req_state(input state_t s);
      return (s == S_FETCH) || (s == S_LDW_REQ) || (s == S_STW_REQ);
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// -----------------------------------------------------------------------------
// mem_wait_timer
// Counts cycles spent waiting on a memory handshake and flags when the wait
// limit has been reached.
// Parameters:
//   LIMIT  number of wait cycles allowed; 0 disables the timer (expired = 0)
//   W      counter width, must hold LIMIT
// Ports:
//   CLK      in   clock, rising edge
//   reset    in   synchronous active-high reset
//   clear    in   force counter to 0 (takes priority over enable)
//   enable   in   count one more wait cycle
//   expired  out  counter has reached LIMIT-1 (last allowed wait cycle)
// -----------------------------------------------------------------------------
module mem_wait_timer #(
   parameter int LIMIT = 16,
   parameter int W     = 8
) (
   input  logic CLK,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [W-1:0] count_reg;

   always_ff @(posedge CLK) begin
      if (reset || clear) begin
         count_reg <= '0;
      end else if (enable) begin
         count_reg <= count_reg + 1'b1;
      end
   end

   generate
      if (LIMIT == 0) begin : g_disabled
         // Counter still runs (and wraps) but can never expire.
         logic count_unused;
         assign count_unused = ^count_reg;
         assign expired      = 1'b0;
      end else begin : g_enabled
         assign expired = (count_reg == W'(LIMIT - 1));
      end
   endgenerate

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_fsm
// Multi-cycle control unit: sequences fetch, decode, ALU, load, store, branch
// and halt; drives datapath enables and memory strobes; memory accesses use a
// req/ack handshake guarded by a watchdog.
//
// Optional build macro: BR_COND_EN
//   defined   - BR_EN/PC_EN in the branch state follow br_flag (not-taken
//               branches still retire with instr_done)
//   undefined - branches are unconditional and br_flag is ignored
//
// Ports:
//   CLK, reset          clock / synchronous active-high reset
//   run                 level; permits leaving IDLE
//   instr               IR contents (low OPW bits are the opcode)
//   mem_ack             memory completion for the current request
//   br_flag             branch condition (BR_COND_EN only)
//   MemRead, MemWrite   memory strobes, held until ack
//   IR_EN, PC_EN, MDR_EN, BR_EN, RFwrite   datapath enables
//   LDW_EN              address mux: 1 = register address, 0 = PC
//   dataW_MDR           RF write mux: 1 = MDR, 0 = ALU
//   instr_done          one-cycle retire pulse
//   halted, fault       sticky status
//   fault_code          0 none, 1 illegal opcode, 2 memory timeout
//   state_dbg           current state encoding
// -----------------------------------------------------------------------------
module cpu_ctrl_fsm
   import cpu_pkg::*;
#(
   parameter int INSTR_W = 16,
   parameter int OPW     = 5,
   parameter int TIMEOUT = 16,
   parameter int TO_W    = 8
) (
   input  logic               CLK,
   input  logic               reset,
   input  logic               run,
   input  logic [INSTR_W-1:0] instr,
   input  logic               mem_ack,
   input  logic               br_flag,
   output logic               MemRead,
   output logic               MemWrite,
   output logic               IR_EN,
   output logic               PC_EN,
   output logic               MDR_EN,
   output logic               BR_EN,
   output logic               RFwrite,
   output logic               LDW_EN,
   output logic               dataW_MDR,
   output logic               instr_done,
   output logic               halted,
   output logic               fault,
   output logic [1:0]         fault_code,
   output logic [3:0]         state_dbg
);

   state_t         state_reg, state_next;
   fault_code_t    fault_code_reg, fault_code_next;
   ctrl_t          ctrl_reg;
   logic [OPW-1:0] op;
   logic           in_req;
   logic           timer_expired;
   logic           timed_out;
   logic           br_take;

   assign op     = instr[OPW-1:0];
   assign in_req = is_req_state(state_reg);

   generate
      if (INSTR_W > OPW) begin : g_instr_hi
         logic instr_hi_unused;
         assign instr_hi_unused = ^instr[INSTR_W-1:OPW];
      end
   endgenerate

   // Held at zero outside request states, so every request starts from 0.
   mem_wait_timer #(
      .LIMIT (TIMEOUT),
      .W     (TO_W)
   ) u_wait_timer (
      .CLK     (CLK),
      .reset   (reset),
      .clear   (~in_req),
      .enable  (in_req & ~mem_ack),
      .expired (timer_expired)
   );

   // An ack on the limit cycle wins over the timeout.
   assign timed_out = in_req & ~mem_ack & timer_expired;

   always_comb begin
      state_next      = state_reg;
      fault_code_next = fault_code_reg;
      case (state_reg)
         S_IDLE:     if (run) state_next = S_FETCH;
         S_FETCH: begin
            if (mem_ack) begin
               state_next = S_LOAD_IR;
            end else if (timed_out) begin
               state_next      = S_FAULT;
               fault_code_next = FC_TIMEOUT;
            end
         end
         S_LOAD_IR:  state_next = S_DECODE;
         S_DECODE: begin
            if (op <= OPW'(OP_EQ)) begin
               state_next = S_AR_ALU;
            end else if (op == OPW'(OP_LDW)) begin
               state_next = S_LDW_REQ;
            end else if (op == OPW'(OP_STW)) begin
               state_next = S_STW_REQ;
            end else if (op == OPW'(OP_BR)) begin
               state_next = S_BR;
            end else if (op == OPW'(OP_HALT)) begin
               state_next = S_HALT;
            end else begin
               state_next      = S_FAULT;
               fault_code_next = FC_ILLEGAL;
            end
         end
         S_AR_ALU:   state_next = S_AR_ROUT;
         S_AR_ROUT:  state_next = S_IDLE;
         S_LDW_REQ: begin
            if (mem_ack) begin
               state_next = S_LDW_MDR;
            end else if (timed_out) begin
               state_next      = S_FAULT;
               fault_code_next = FC_TIMEOUT;
            end
         end
         S_LDW_MDR:  state_next = S_LDW_ROUT;
         S_LDW_ROUT: state_next = S_IDLE;
         S_STW_REQ: begin
            if (mem_ack) begin
               state_next = S_IDLE;
            end else if (timed_out) begin
               state_next      = S_FAULT;
               fault_code_next = FC_TIMEOUT;
            end
         end
         S_BR:       state_next = S_IDLE;
         S_HALT:     state_next = S_HALT;
         S_FAULT:    state_next = S_FAULT;
         default:    state_next = S_IDLE;
      endcase
   end

   // Moore outputs are registered from the next state, so they always equal
   // the decode of state_reg and are all 0 right after reset.
   always_ff @(posedge CLK) begin
      if (reset) begin
         state_reg      <= S_IDLE;
         fault_code_reg <= FC_NONE;
         ctrl_reg       <= '0;
      end else begin
         state_reg      <= state_next;
         fault_code_reg <= fault_code_next;
         ctrl_reg       <= state_ctrl(state_next);
      end
   end

`ifdef BR_COND_EN
   assign br_take = br_flag;
`else
   logic br_flag_unused;
   assign br_flag_unused = br_flag;
   assign br_take        = 1'b1;
`endif

   assign MemRead    = ctrl_reg.mem_read;
   assign MemWrite   = ctrl_reg.mem_write;
   assign IR_EN      = ctrl_reg.ir_en;
   assign MDR_EN     = ctrl_reg.mdr_en;
   assign RFwrite    = ctrl_reg.rf_write;
   assign LDW_EN     = ctrl_reg.ldw_en;
   assign dataW_MDR  = ctrl_reg.data_w_mdr;
   assign halted     = ctrl_reg.halted;
   assign fault      = ctrl_reg.fault;
   assign BR_EN      = ctrl_reg.br_en & br_take;
   // PC increments in the fetch cycle that receives ack; the registered
   // pc_en bit only covers the branch state.
   assign PC_EN      = (ctrl_reg.pc_en & br_take) | ((state_reg == S_FETCH) & mem_ack);
   // A store retires in the same cycle its ack arrives.
   assign instr_done = ctrl_reg.instr_done | ((state_reg == S_STW_REQ) & mem_ack);
   assign fault_code = fault_code_reg;
   assign state_dbg  = state_reg;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
module tb_cpu_ctrl_fsm;
   localparam int INSTR_W = 16;
   localparam int OPW     = 5;
   localparam int TIMEOUT = 16;
   localparam int TO_W    = 8;
   localparam int NEVER   = 1000;
   localparam int K_RET   = 0;
   localparam int K_HALT  = 1;
   localparam int K_FAULT = 2;

   logic               CLK = 1'b0;
   logic               reset, run, mem_ack, br_flag;
   logic [INSTR_W-1:0] instr;
   logic MemRead, MemWrite, IR_EN, PC_EN, MDR_EN, BR_EN, RFwrite, LDW_EN;
   logic dataW_MDR, instr_done, halted, fault;
   logic [1:0] fault_code;
   logic [3:0] state_dbg;
   logic [11:0] outs;

   assign outs = {MemRead, MemWrite, IR_EN, PC_EN, MDR_EN, BR_EN, RFwrite,
                  LDW_EN, dataW_MDR, instr_done, halted, fault};

   always #5 CLK = ~CLK;

   cpu_ctrl_fsm #(.INSTR_W(INSTR_W), .OPW(OPW), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
      .CLK(CLK), .reset(reset), .run(run), .instr(instr), .mem_ack(mem_ack),
      .br_flag(br_flag), .MemRead(MemRead), .MemWrite(MemWrite), .IR_EN(IR_EN),
      .PC_EN(PC_EN), .MDR_EN(MDR_EN), .BR_EN(BR_EN), .RFwrite(RFwrite),
      .LDW_EN(LDW_EN), .dataW_MDR(dataW_MDR), .instr_done(instr_done),
      .halted(halted), .fault(fault), .fault_code(fault_code), .state_dbg(state_dbg)
   );

   typedef struct {
      int op;
      int kind;
      int code;
      int lat;
      int mem_read;
      int mem_write;
      int ldw_en;
      int ir_en;
      int pc_en;
      int mdr_en;
      int br_en;
      int rf_write;
      int rf_mdr;
      int dw_mdr;
   } resp_t;

   int    total = 0;
   int    bad   = 0;
   int    ev_cnt = 0;
   int    delay_q[$];
   resp_t exp_q[$];

   task automatic chk(input string name, input int act, input int want);
      total++;
      if (act != want) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, want);
      end
   endtask

   // Reference: expected outcome of one instruction from the opcode class,
   // ack delays (cycles of waiting before ack) and branch flag.
   function automatic resp_t model(input int op, input int fd, input int md, input bit flag);
      resp_t r;
      int    taken;
      r = '{default: 0};
      r.op = op;
      taken = 1;
`ifdef BR_COND_EN
      taken = int'(flag);
`else
      if (flag) taken = 1;
`endif
      if (TIMEOUT != 0 && fd >= TIMEOUT) begin
         r.kind = K_FAULT; r.code = 2; r.mem_read = TIMEOUT; r.lat = TIMEOUT + 1;
         return r;
      end
      r.mem_read = fd + 1; r.pc_en = 1; r.ir_en = 1;
      r.lat = fd + 1 + 2;                       // fetch wait + load IR + decode
      if (op <= 16) begin
         r.rf_write = 1; r.lat += 2;
      end else if (op == 17) begin
         r.pc_en += taken; r.br_en = taken; r.lat += 1;
      end else if (op == 18 || op == 19) begin
         if (TIMEOUT != 0 && md >= TIMEOUT) begin
            r.kind = K_FAULT; r.code = 2; r.ldw_en = TIMEOUT;
            if (op == 19) r.mem_read += TIMEOUT; else r.mem_write = TIMEOUT;
            r.lat += TIMEOUT + 1;
         end else begin
            r.ldw_en = md + 1;
            if (op == 19) begin
               r.mem_read += md + 1; r.mdr_en = 1; r.rf_write = 1; r.rf_mdr = 1; r.dw_mdr = 1;
               r.lat += md + 1 + 2;
            end else begin
               r.mem_write = md + 1; r.lat += md + 1;
            end
         end
      end else if (op == 20) begin
         r.kind = K_HALT; r.lat += 1;
      end else begin
         r.kind = K_FAULT; r.code = 1; r.lat += 1;
      end
      return r;
   endfunction

   // Memory responder: each new request pops its wait delay, then acks once.
   initial begin
      int req_cnt;
      int cur_delay;
      req_cnt = 0; cur_delay = 0; mem_ack = 1'b0;
      forever begin
         @(posedge CLK); #1;
         if (!(MemRead || MemWrite)) begin
            req_cnt = 0; mem_ack = 1'b0;
         end else begin
            if (req_cnt == 0) begin
               cur_delay = 0;
               if (delay_q.size() > 0) cur_delay = delay_q.pop_front();
            end
            mem_ack = (req_cnt == cur_delay);
            req_cnt++;
         end
      end
   end

   // Monitor: accumulates activity from the first fetch cycle to the retire /
   // halt / fault cycle, then checks it against the scoreboard head.
   initial begin
      resp_t a, e;
      bit    active;
      active = 0;
      a = '{default: 0};
      forever begin
         @(negedge CLK);
         if (reset) begin
            active = 0;
         end else begin
            if (!active && MemRead) begin
               active = 1; a = '{default: 0};
            end
            if (active) begin
               a.lat++;
               a.mem_read  += int'(MemRead);
               a.mem_write += int'(MemWrite);
               a.ldw_en    += int'(LDW_EN);
               a.ir_en     += int'(IR_EN);
               a.pc_en     += int'(PC_EN);
               a.mdr_en    += int'(MDR_EN);
               a.br_en     += int'(BR_EN);
               a.rf_write  += int'(RFwrite);
               a.rf_mdr    += int'(RFwrite && dataW_MDR);
               a.dw_mdr    += int'(dataW_MDR);
               if (instr_done || halted || fault) begin
                  a.kind = instr_done ? K_RET : (halted ? K_HALT : K_FAULT);
                  a.code = int'(fault_code);
                  if (exp_q.size() == 0) begin
                     total++; bad++;
                     $display("FAIL unexpected_event: got kind %0d, expected none", a.kind);
                  end else begin
                     e = exp_q.pop_front();
                     chk("kind", a.kind, e.kind);
                     chk("fault_code", a.code, e.code);
                     chk("latency", a.lat, e.lat);
                     chk("MemRead_cycles", a.mem_read, e.mem_read);
                     chk("MemWrite_cycles", a.mem_write, e.mem_write);
                     chk("LDW_EN_cycles", a.ldw_en, e.ldw_en);
                     chk("IR_EN_cycles", a.ir_en, e.ir_en);
                     chk("PC_EN_cycles", a.pc_en, e.pc_en);
                     chk("MDR_EN_cycles", a.mdr_en, e.mdr_en);
                     chk("BR_EN_cycles", a.br_en, e.br_en);
                     chk("RFwrite_cycles", a.rf_write, e.rf_write);
                     chk("RFwrite_from_MDR", a.rf_mdr, e.rf_mdr);
                     chk("dataW_MDR_cycles", a.dw_mdr, e.dw_mdr);
                     $display("txn op=%0d kind=%0d code=%0d latency=%0d (expected kind=%0d latency=%0d)",
                              e.op, a.kind, a.code, a.lat, e.kind, e.lat);
                  end
                  active = 0;
                  ev_cnt++;
               end
            end
         end
      end
   end

   task automatic check_idle(input string tag);
      chk({tag, "_outputs_zero"}, int'(outs), 0);
      chk({tag, "_fault_code_zero"}, int'(fault_code), 0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge CLK); #1;
      reset = 1'b0;
      delay_q.delete();
      check_idle("after_reset");
   endtask

   task automatic run_txn(input int op, input int fd, input int md, input bit flag);
      resp_t e;
      int    start;
      e = model(op, fd, md, flag);
      instr = INSTR_W'($urandom);          // upper bits must be ignored
      instr[OPW-1:0] = OPW'(op);
      br_flag = flag;
      delay_q.push_back(fd);
      if ((op == 18 || op == 19) && !(TIMEOUT != 0 && fd >= TIMEOUT)) delay_q.push_back(md);
      exp_q.push_back(e);
      start = ev_cnt;
      run = 1'b1;
      @(posedge CLK); #1;
      run = 1'b0;
      for (int c = 0; c < 200 && ev_cnt == start; c++) begin
         @(posedge CLK); #1;
      end
      if (ev_cnt == start) begin
         total++; bad++;
         $display("FAIL txn_timeout: op %0d got no event, expected kind %0d", op, e.kind);
         exp_q.delete();
         do_reset();
         return;
      end
      if (e.kind != K_RET) begin
         // Halt / fault are sticky: run toggling must not restart anything.
         for (int c = 0; c < 4; c++) begin
            run = c[0];
            @(posedge CLK); #1;
            chk("sticky_halted", int'(halted), int'(e.kind == K_HALT));
            chk("sticky_fault", int'(fault), int'(e.kind == K_FAULT));
            chk("sticky_fault_code", int'(fault_code), e.code);
            chk("sticky_no_MemRead", int'(MemRead), 0);
         end
         run = 1'b0;
         do_reset();
      end
   endtask

   int d_op[11] = '{0, 19, 18,    25, 20, 17, 17, 0,  16, 19, 18};
   int d_fd[11] = '{0, 3,  0,     0,  0,  1,  2,  15, 16, 0,  1};
   int d_md[11] = '{0, 3,  NEVER, 0,  0,  0,  0,  0,  0,  15, 2};
   int d_fl[11] = '{0, 0,  0,     0,  0,  0,  1,  0,  0,  0,  1};

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not complete, expected finish");
      $fatal(1, "global timeout");
   end

   initial begin
      bit found;
      reset = 1'b1; run = 1'b0; br_flag = 1'b0; instr = '0;
      repeat (3) @(posedge CLK);
      #1;
      reset = 1'b0;
      check_idle("reset");

      for (int i = 0; i < 11; i++) run_txn(d_op[i], d_fd[i], d_md[i], d_fl[i] != 0);

      // Reset while in LDW_MDR abandons the load: no RF write afterwards.
      instr = INSTR_W'(19); br_flag = 1'b0;
      delay_q.push_back(0); delay_q.push_back(0);
      run = 1'b1;
      @(posedge CLK); #1;
      run = 1'b0;
      found = 0;
      for (int c = 0; c < 50; c++) begin
         if (MDR_EN) begin found = 1; break; end
         @(posedge CLK); #1;
      end
      chk("reached_LDW_MDR", int'(found), 1);
      reset = 1'b1;
      @(posedge CLK); #1;
      reset = 1'b0;
      delay_q.delete();
      for (int c = 0; c < 5; c++) begin
         chk("abandon_MDR_EN", int'(MDR_EN), 0);
         chk("abandon_RFwrite", int'(RFwrite), 0);
         chk("abandon_instr_done", int'(instr_done), 0);
         chk("abandon_MemRead", int'(MemRead), 0);
         chk("abandon_fault_code", int'(fault_code), 0);
         @(posedge CLK); #1;
      end

      for (int i = 0; i < 40; i++) begin
         int r, op, fd, md;
         r = int'($urandom_range(0, 99));
         if (r < 30)      op = int'($urandom_range(0, 16));
         else if (r < 45) op = 17;
         else if (r < 65) op = 19;
         else if (r < 80) op = 18;
         else if (r < 87) op = 20;
         else             op = int'($urandom_range(21, 31));
         fd = ($urandom_range(0, 99) < 4) ? NEVER : int'($urandom_range(0, 3));
         r  = int'($urandom_range(0, 99));
         md = (r < 6) ? NEVER : ((r < 12) ? TIMEOUT - 1 : int'($urandom_range(0, 4)));
         run_txn(op, fd, md, $urandom_range(0, 1) != 0);
      end

      chk("scoreboard_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
